// File: rtl/dec16_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec16_timer_pkg
// Description : Shared definitions for the dec16_timer countdown timer:
//               default widths and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dec16_timer_pkg;

    // Default counter / reload register width.
    localparam int c_width = 16;

    // Default prescaler compare width.
    localparam int c_pw = 8;

    // Controller states. The encodings are fixed so that other blocks
    // decoding the timer state see stable values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage : dec16_timer_pkg
`default_nettype wire

// File: rtl/dec16_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : dec16_timer_if
// Description : Control / status bundle of the dec16_timer.
//               master : drives load, load_value, start, stop, auto_reload,
//                        prescale; observes count, running, done, tc.
//               slave  : the timer itself (opposite directions).
// Revision    : 1.0 - initial release
// ============================================================================
interface dec16_timer_if
    import dec16_timer_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int PW    = c_pw
) ();

    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [PW-1:0]    prescale;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic             tc;

    modport master (
        output load,
        output load_value,
        output start,
        output stop,
        output auto_reload,
        output prescale,
        input  count,
        input  running,
        input  done,
        input  tc
    );

    modport slave (
        input  load,
        input  load_value,
        input  start,
        input  stop,
        input  auto_reload,
        input  prescale,
        output count,
        output running,
        output done,
        output tc
    );

endinterface : dec16_timer_if
`default_nettype wire

// File: rtl/dec16_timer_prescaler_tick.sv
`default_nettype none
// ============================================================================
// Module      : dec16_timer_prescaler_tick
// Description : PW-bit prescale counter. Flags a tick whenever the counter
//               has reached or passed the prescale compare value; the
//               counter returns to zero on a tick while enabled.
// Ports       : clock, reset_n  - clock, asynchronous active-low reset
//               clear           - force the counter to zero (wins over enable)
//               enable          - advance the counter this cycle
//               prescale        - compare value (tick every prescale+1 clocks)
//               tick            - counter >= prescale
// Revision    : 1.0 - initial release
// ============================================================================
module dec16_timer_prescaler_tick
    import dec16_timer_pkg::*;
#(
    parameter int PW = c_pw
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    input  wire logic          clear,
    input  wire logic          enable,
    input  wire logic [PW-1:0] prescale,
    output logic               tick
);

    localparam logic [PW-1:0] c_pc_one = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] r_pc;

    // Greater-or-equal rather than equality: if prescale is lowered below
    // the current count mid-run, the next cycle still ticks instead of
    // running all the way round the PW-bit range.
    assign tick = (r_pc >= prescale);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else if (clear) begin
            r_pc <= '0;
        end else if (enable) begin
            r_pc <= tick ? '0 : (r_pc + c_pc_one);
        end
    end

endmodule : dec16_timer_prescaler_tick
`default_nettype wire

// File: rtl/dec16_timer.sv
`default_nettype none
// ============================================================================
// Module      : dec16_timer
// Description : Loadable WIDTH-bit countdown timer with programmable
//               prescaler, one-shot / auto-reload modes and a one-cycle
//               terminal-count pulse. Input priority: load > stop > start.
// Ports       : clock    - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - dec16_timer_if.slave: load, load_value, start,
//                          stop, auto_reload, prescale in;
//                          count, running, done, tc out (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module dec16_timer
    import dec16_timer_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int PW    = c_pw
) (
    input  wire logic    clock,
    input  wire logic    reset_n,
    dec16_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc;
    logic             w_tc_nxt;

    logic             w_pc_clear;
    logic             w_pc_en;
    logic             w_tick;

    logic [WIDTH-1:0] w_count_dec;
    logic             w_count_zero;
    logic             w_count_one;
    logic             w_reload_zero;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    dec16_timer_prescaler_tick #(
        .PW (PW)
    ) u_prescaler (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (w_pc_clear),
        .enable   (w_pc_en),
        .prescale (bus.prescale),
        .tick     (w_tick)
    );

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    // Decrement as an add of all-ones (two's-complement -1), the mirror of
    // the incrementer. Only used when count > 1, so it can never wrap.
    assign w_count_dec   = r_count + c_all_ones;
    assign w_count_zero  = (r_count == '0);
    assign w_count_one   = (r_count == c_one);
    assign w_reload_zero = (r_reload == '0);

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        w_pc_clear   = 1'b0;
        w_pc_en      = 1'b0;

        if (bus.load) begin
            // Load wins over everything, including a coincident terminal
            // tick, so no tc is produced in that cycle.
            w_count_nxt  = bus.load_value;
            w_reload_nxt = bus.load_value;
            w_state_nxt  = ST_IDLE;
            w_pc_clear   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_pc_clear = 1'b1;
                    if (!bus.stop && bus.start && !w_count_zero) begin
                        w_state_nxt = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (bus.stop) begin
                        // Pause: count holds, prescaler restarts on resume.
                        w_state_nxt = ST_IDLE;
                        w_pc_clear  = 1'b1;
                    end else begin
                        w_pc_en = 1'b1;
                        if (w_tick) begin
                            if (w_count_zero) begin
                                // Not reachable through normal operation;
                                // parks safely instead of wrapping.
                                w_state_nxt = ST_DONE;
                            end else if (w_count_one) begin
                                w_tc_nxt = 1'b1;
                                if (bus.auto_reload && !w_reload_zero) begin
                                    w_count_nxt = r_reload;
                                end else begin
                                    w_count_nxt = '0;
                                    w_state_nxt = ST_DONE;
                                end
                            end else begin
                                w_count_nxt = w_count_dec;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    w_pc_clear = 1'b1;
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pc_clear  = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign bus.count   = r_count;
    assign bus.running = (r_state == ST_RUN);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.tc      = r_tc;

endmodule : dec16_timer
`default_nettype wire

// File: tb/tb_dec16_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec16_timer
// Description : Self-checking bench for dec16_timer. A behavioural model of
//               the timer is stepped every clock and compared against the
//               DUT outputs on every falling edge; directed scenarios add
//               hand-computed literal expectations, followed by randomized
//               stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec16_timer;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    dec16_timer_if bus ();

    dec16_timer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        int count;
        int reload;
        int pc;
        bit run;
        bit done;
        bit tc;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t s, bit ld, int lv, bit st,
                                          bit sp, bit ar, int ps);
        model_t n;
        n    = s;
        n.tc = 1'b0;
        if (ld) begin
            n.count  = lv;
            n.reload = lv;
            n.pc     = 0;
            n.run    = 1'b0;
            n.done   = 1'b0;
        end else if (s.run) begin
            if (sp) begin
                n.run = 1'b0;
                n.pc  = 0;
            end else if (s.pc >= ps) begin
                n.pc = 0;
                if (s.count > 1) begin
                    n.count = s.count - 1;
                end else begin
                    n.tc = 1'b1;
                    if (ar && s.reload != 0) begin
                        n.count = s.reload;
                    end else begin
                        n.count = 0;
                        n.run   = 1'b0;
                        n.done  = 1'b1;
                    end
                end
            end else begin
                n.pc = s.pc + 1;
            end
        end else if (!s.done) begin
            if (!sp && st && s.count != 0) begin
                n.run = 1'b1;
                n.pc  = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m <= '0;
        end else begin
            m <= model_next(m, bus.load, int'(bus.load_value), bus.start,
                            bus.stop, bus.auto_reload, int'(bus.prescale));
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_count",   32'(bus.count),   32'(m.count));
            chk("model_running", 32'(bus.running), 32'(m.run));
            chk("model_done",    32'(bus.done),    32'(m.done));
            chk("model_tc",      32'(bus.tc),      32'(m.tc));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load_value = v;
        bus.load       = 1'b1;
        tick();
        bus.load       = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;

        reset_n         = 1'b0;
        bus.load        = 1'b0;
        bus.load_value  = '0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;
        bus.prescale    = '0;

        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_count",   32'(bus.count),   32'd0);
        chk("rst_running", 32'(bus.running), 32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_tc",      32'(bus.tc),      32'd0);
        reset_n = 1'b1;
        tick();

        // One-shot, prescale 0: 5,4,3,2,1,0 on consecutive clocks.
        do_load(16'd5);
        chk("t1_load", 32'(bus.count), 32'd5);
        do_start();
        chk("t1_run",   32'(bus.running), 32'd1);
        chk("t1_first", 32'(bus.count),   32'd5);
        for (int k = 4; k >= 1; k--) begin
            tick();
            chk("t1_count", 32'(bus.count), 32'(k));
            chk("t1_no_tc", 32'(bus.tc),    32'd0);
        end
        tick();
        chk("t1_zero",    32'(bus.count),   32'd0);
        chk("t1_tc",      32'(bus.tc),      32'd1);
        chk("t1_done",    32'(bus.done),    32'd1);
        chk("t1_stopped", 32'(bus.running), 32'd0);
        tick();
        chk("t1_tc_once", 32'(bus.tc),   32'd0);
        chk("t1_done_hold", 32'(bus.done), 32'd1);
        do_start();
        chk("t1_done_ignores_start", 32'(bus.done), 32'd1);

        // Prescale 2, load 3: tc 9 clocks after the start edge.
        bus.prescale = 8'd2;
        do_load(16'd3);
        do_start();
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 3) chk("t2_count_at3", 32'(bus.count), 32'd2);
            if (bus.tc === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("t2_tc_latency", 32'(lat), 32'd9);

        // Auto-reload 2, prescale 0: 1,2,1,2... with tc every 2 clocks.
        bus.prescale    = 8'd0;
        bus.auto_reload = 1'b1;
        do_load(16'd2);
        do_start();
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("t3_count", 32'(bus.count), (i % 2 == 1) ? 32'd1 : 32'd2);
            chk("t3_tc",    32'(bus.tc),    (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_done",  32'(bus.done),  32'd0);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;
        chk("t3_stopped", 32'(bus.running), 32'd0);

        // Full-range load, stop after 10 clocks, resume.
        do_load(16'hFFFF);
        do_start();
        repeat (10) tick();
        chk("t4_before_stop", 32'(bus.count), 32'hFFF5);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t4_held",    32'(bus.count),   32'hFFF5);
        chk("t4_paused",  32'(bus.running), 32'd0);
        repeat (3) tick();
        chk("t4_still_held", 32'(bus.count), 32'hFFF5);
        do_start();
        chk("t4_resumed", 32'(bus.running), 32'd1);
        tick();
        chk("t4_next", 32'(bus.count), 32'hFFF4);

        // Load colliding with the terminal tick: load wins, no tc.
        do_load(16'd4);
        do_start();
        repeat (3) tick();
        chk("t5_at_one", 32'(bus.count), 32'd1);
        do_load(16'd7);
        chk("t5_count",   32'(bus.count),   32'd7);
        chk("t5_idle",    32'(bus.running), 32'd0);
        chk("t5_no_tc",   32'(bus.tc),      32'd0);
        chk("t5_no_done", 32'(bus.done),    32'd0);
        do_load(16'd0);
        do_start();
        chk("t5_zero_start", 32'(bus.running), 32'd0);
        chk("t5_zero_count", 32'(bus.count),   32'd0);

        // Asynchronous reset between edges while running.
        do_load(16'd100);
        do_start();
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_count",   32'(bus.count),   32'd0);
        chk("t6_rst_running", 32'(bus.running), 32'd0);
        chk("t6_rst_tc",      32'(bus.tc),      32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("t6_after_idle",  32'(bus.running), 32'd0);
        chk("t6_after_count", 32'(bus.count),   32'd0);

        // Randomized stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.load       = ($urandom_range(0, 15) == 0);
            bus.load_value = ($urandom_range(0, 7) == 0) ?
                             16'($urandom_range(0, 65535)) :
                             16'($urandom_range(0, 12));
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.stop       = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) bus.auto_reload = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) bus.prescale = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
                tick();
                #2 reset_n = 1'b1;
            end
            tick();
        end

        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dec16_timer
`default_nettype wire

// File: doc/dec16_timer.md
Name: dec16_timer

Overview:
- 16-bit loadable countdown timer with a programmable prescaler, one-shot and auto-reload modes, and a one-cycle terminal-count pulse.
- It is the decrementing counterpart to the Inc16 datapath, and the first clocked counter block in the 02 arithmetic set.
- It feeds interval and timeout logic in later register/CPU stages.

Parameters:
- WIDTH, 16, counter and reload register width.
- PW, 8, prescaler compare width.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  load load_value into count and reload register.
- load_value  input  WIDTH  value captured by load.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting, holding count.
- auto_reload  input  1  1 = reload at terminal count; 0 = one-shot.
- prescale  input  PW  ticks occur every prescale+1 clocks while running.
- count  output  WIDTH  current counter value.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE, until the next load.
- tc  output  1  one-cycle terminal-count pulse.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset (reset_n=0, takes effect immediately, no clock required):
  - count=0, reload_reg=0, prescaler pc=0, state=IDLE.
  - running=0, done=0, tc=0.
- Reset mid-RUN aborts the count. No tc is generated.
- All outputs are registered. running and done decode from the state register.
- States: IDLE, RUN, DONE.
- Input priority per cycle: load > stop > start.
- load (any state):
  - count<=load_value, reload_reg<=load_value, pc<=0, state<=IDLE, tc<=0.
  - done therefore clears.
- IDLE:
  - start with count!=0 -> RUN, pc<=0.
  - start with count==0 -> ignored, stay IDLE.
- RUN, each cycle:
  - If pc>=prescale: this is a tick, and pc<=0.
  - Otherwise pc<=pc+1.
  - The >= compare means a prescale lowered mid-run never wraps pc.
- Tick with count>1: count<=count-1.
- Tick with count==1 (terminal):
  - tc<=1 for exactly one cycle.
  - If auto_reload=1 and reload_reg!=0: count<=reload_reg, stay RUN, pc<=0.
  - Otherwise count<=0, state<=DONE.
  - auto_reload is sampled only at the terminal tick.
- Resulting periods:
  - prescale=0 gives one decrement per clock.
  - Load N, start: tc rises N*(prescale+1) clocks after the start edge.
- stop in RUN: state<=IDLE, count held, pc<=0. A later start resumes from the held count.
- DONE:
  - count=0, running=0, done=1.
  - start is ignored (count==0). stop is ignored.
  - Only load or reset leaves DONE.
- Simultaneous events:
  - load together with a terminal tick: load wins, and tc is not asserted.
  - stop together with a terminal tick: stop wins, count holds at 1, no tc.
  - start while already in RUN: no effect; pc is not cleared.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - count never decrements below 0 and never wraps to all-ones.
  - load_value=16'hFFFF is legal and gives 65535 ticks.

Decomposition:
- Shared package/include (gates.v companion header):
  - State encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - WIDTH default.
- One natural sub-module, prescaler_tick:
  - PW-bit counter with clear input.
  - Outputs a tick when pc>=prescale.
- The decrement reuses the existing 16-bit adder with an all-ones operand, the mirror of Inc16.

Test Plan:
- Reset, then load_value=5, load, prescale=0, auto_reload=0, start -> count 5,4,3,2,1,0 on consecutive clocks. tc high for 1 cycle when count=0. done=1, running=0 after.
- load 3, prescale=2, start -> count decrements every 3 clocks. tc asserted 9 clocks after the start edge.
- load 2, auto_reload=1, prescale=0, start, run 12 clocks -> count 2,1,2,1,... with tc pulsing every 2 clocks. done stays 0.
- load 16'hFFFF, start, stop after 10 clocks -> count=16'hFFF5 held. start -> resumes at FFF4 on the next tick.
- load 4, start, drive load_value=7 with load on the terminal-tick cycle of a count at 1 -> count=7, state IDLE, tc=0. Separately, start with count=0 -> stays IDLE.
- RUN with count=100, drop reset_n between edges -> count=0, running=0, tc=0 immediately. Release -> remains IDLE.
